// File: rtl/ex_18_pkg.sv
// ex_18_pkg: minterm set masks, class enum and the minterm classifier
// shared by the ex_18 function block.
package ex_18_pkg;

    // Bit i of each mask corresponds to minterm i of {A,B,C}.
    localparam logic [7:0] ON_SET  = 8'b1000_0010;
    localparam logic [7:0] DC_SET  = 8'b0010_1000;
    localparam logic [7:0] OFF_SET = 8'b0101_0101;

    typedef enum logic [1:0] {
        CLS_OFF = 2'd0,
        CLS_ON  = 2'd1,
        CLS_DC  = 2'd2
    } cls_e;

    // Map a 3-bit minterm index onto its class in the function specification.
    function automatic cls_e classify(input logic [2:0] m);
        if (ON_SET[m]) begin
            return CLS_ON;
        end else if (DC_SET[m]) begin
            return CLS_DC;
        end else begin
            return CLS_OFF;
        end
    endfunction

endpackage

// File: rtl/ex_18_sat_cnt.sv
// ex_18_sat_cnt: CNT_W-bit up-counter that sticks at all-ones instead of
// wrapping. Cleared by the asynchronous active-low reset.
module ex_18_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Count up on inc, holding once the maximum value is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/ex_18.sv
// ex_18: three-input function block, F = C (minterms 3 and 5 are don't-cares
// resolved to 1). Combinational F plus a strobe-qualified registered path.
// Optional per-class saturating counters are built when EX_18_CLASS_CNT_EN
// is defined; otherwise the count ports are tied to zero.
module ex_18
    import ex_18_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             in_vld,
    output logic             F,
    output logic             f_q,
    output logic             out_vld,
    output logic             dc_q,
    output logic [CNT_W-1:0] on_cnt,
    output logic [CNT_W-1:0] off_cnt,
    output logic [CNT_W-1:0] dc_cnt
);

    logic [2:0] m;

    assign m = {A, B, C};

    // Minimised cover: the don't-cares fold into the C term, so F is just C.
    // X/Z on C reaches F untouched.
    assign F = C;

    // Registered result, don't-care flag and the one-cycle output strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q     <= 1'b0;
            dc_q    <= 1'b0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= in_vld;
            if (in_vld) begin
                f_q  <= C;
                dc_q <= DC_SET[m];
            end
        end
    end

`ifdef EX_18_CLASS_CNT_EN
    cls_e cls;

    assign cls = classify(m);

    ex_18_sat_cnt #(.CNT_W(CNT_W)) u_on_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (in_vld && (cls == CLS_ON)),
        .cnt   (on_cnt)
    );

    ex_18_sat_cnt #(.CNT_W(CNT_W)) u_off_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (in_vld && (cls == CLS_OFF)),
        .cnt   (off_cnt)
    );

    ex_18_sat_cnt #(.CNT_W(CNT_W)) u_dc_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (in_vld && (cls == CLS_DC)),
        .cnt   (dc_cnt)
    );
`else
    assign on_cnt  = '0;
    assign off_cnt = '0;
    assign dc_cnt  = '0;
`endif

endmodule

// File: tb/tb_ex_18.sv
// tb_ex_18: scoreboard bench for ex_18. Two instances share the inputs:
// one at the default counter width and one at CNT_W=2 to reach saturation.
module tb_ex_18;

`ifdef EX_18_CLASS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic A = 1'b0, B = 1'b0, C = 1'b0, in_vld = 1'b0;

    logic       F8, fq8, ov8, dcq8;
    logic [7:0] on8, off8, dc8;
    logic       F2, fq2, ov2, dcq2;
    logic [1:0] on2, off2, dc2;

    ex_18 #(.CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .in_vld(in_vld),
        .F(F8), .f_q(fq8), .out_vld(ov8), .dc_q(dcq8),
        .on_cnt(on8), .off_cnt(off8), .dc_cnt(dc8)
    );

    ex_18 #(.CNT_W(2)) u_small (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .in_vld(in_vld),
        .F(F2), .f_q(fq2), .out_vld(ov2), .dc_q(dcq2),
        .on_cnt(on2), .off_cnt(off2), .dc_cnt(dc2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic f;
        logic dc;
        int   on_w8, off_w8, dc_w8;
        int   on_w2, off_w2, dc_w2;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: raw per-class sample counts since reset.
    int n_on = 0, n_off = 0, n_dc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        if (!CNT_EN) return 0;
        return (n > mx) ? mx : n;
    endfunction

    // Drive one cycle of stimulus just after a rising edge; strobed samples
    // update the model and queue the expected registered response.
    task automatic drive(input logic [2:0] m, input bit v);
        exp_t e;
        @(posedge clk);
        #1;
        {A, B, C} = m;
        in_vld = v;
        if (v) begin
            if (m == 3'd1 || m == 3'd7) n_on++;
            else if (m == 3'd3 || m == 3'd5) n_dc++;
            else n_off++;
            e.f  = (m == 3'd1 || m == 3'd3 || m == 3'd5 || m == 3'd7);
            e.dc = (m == 3'd3 || m == 3'd5);
            e.on_w8 = sat(n_on, 8);  e.off_w8 = sat(n_off, 8);  e.dc_w8 = sat(n_dc, 8);
            e.on_w2 = sat(n_on, 2);  e.off_w2 = sat(n_off, 2);  e.dc_w2 = sat(n_dc, 2);
            sb_q.push_back(e);
        end
    endtask

    task automatic drain();
        drive(3'd0, 1'b0);
        repeat (3) @(posedge clk);
        check("sb_drained", sb_q.size(), 0);
    endtask

    // Monitor: on each falling edge, pop and compare whenever out_vld is up.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("ov_match", ov2, ov8);
            if (ov8) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out_vld", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("f_q",      fq8,  e.f);
                    check("dc_q",     dcq8, e.dc);
                    check("on_cnt",   on8,  e.on_w8);
                    check("off_cnt",  off8, e.off_w8);
                    check("dc_cnt",   dc8,  e.dc_w8);
                    check("f_q_w2",   fq2,  e.f);
                    check("dc_q_w2",  dcq2, e.dc);
                    check("on_cnt_w2",  on2,  e.on_w2);
                    check("off_cnt_w2", off2, e.off_w2);
                    check("dc_cnt_w2",  dc2,  e.dc_w2);
                end
            end
        end
    end

    initial begin
        logic [2:0] mv;

        // Combinational truth table while held in reset.
        for (int i = 0; i < 8; i++) begin
            mv = i[2:0];
            {A, B, C} = mv;
            #1;
            check($sformatf("F_m%0d", i), F8, (i % 2 == 1));
            check($sformatf("F_w2_m%0d", i), F2, (i % 2 == 1));
        end
        C = 1'bx;
        #1;
        check("F_x_prop", F8, 1'bx);
        C = 1'b0;
        #1;

        // Reset state.
        check("rst_f_q", fq8, 0);
        check("rst_dc_q", dcq8, 0);
        check("rst_out_vld", ov8, 0);
        check("rst_cnts", {on8, off8, dc8}, 0);
        check("rst_cnts_w2", {on2, off2, dc2}, 0);

        @(negedge clk);
        rst_n = 1'b1;

        // Directed: don't-care strobe, then back-to-back on/on/off.
        drive(3'b011, 1'b1);
        drive(3'b000, 1'b0);
        drive(3'b001, 1'b1);
        drive(3'b111, 1'b1);
        drive(3'b000, 1'b1);
        drain();

        // Saturate the narrow instance's off counter.
        for (int i = 0; i < 5; i++) drive(3'b000, 1'b1);
        drive(3'b101, 1'b1);
        drain();

        // Randomised stream with random strobe gaps.
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 7), ($urandom_range(0, 3) != 0));
        end
        drain();

        // Asynchronous reset between edges after activity.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_f_q", fq8, 0);
        check("arst_dc_q", dcq8, 0);
        check("arst_out_vld", ov8, 0);
        check("arst_cnts", {on8, off8, dc8}, 0);
        check("arst_cnts_w2", {on2, off2, dc2}, 0);
        C = 1'b1;
        #1;
        check("arst_F_hi", F8, 1);
        C = 1'b0;
        #1;
        check("arst_F_lo", F8, 0);
        n_on = 0; n_off = 0; n_dc = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Strobe on the first edge after reset release, then more random.
        {A, B, C} = 3'b111;
        in_vld = 1'b1;
        begin
            exp_t e;
            n_on++;
            e.f = 1'b1; e.dc = 1'b0;
            e.on_w8 = sat(n_on, 8); e.off_w8 = 0; e.dc_w8 = 0;
            e.on_w2 = sat(n_on, 2); e.off_w2 = 0; e.dc_w2 = 0;
            sb_q.push_back(e);
        end
        for (int i = 0; i < 100; i++) begin
            drive($urandom_range(0, 7), ($urandom_range(0, 1) != 0));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
